// File: rtl/num_gen_if.sv
// Valid/ready number stream between a generator (master) and its consumer (slave).
interface num_gen_if #(
  parameter int NUM_SIZE = 12
) ();
  logic [NUM_SIZE-1:0] num;
  logic                valid;
  logic                ready;

  modport master (output num, output valid, input  ready);
  modport slave  (input  num, input  valid, output ready);
endinterface

// File: rtl/num_gen.sv
// Reseedable LFSR number source emitting TESTNUM mode-shaped numbers per run over valid/ready.
// valid rises the cycle after start is accepted; num/cnt hold while ready is low, one transfer per cycle otherwise.
module num_gen #(
  parameter int          NUM_SIZE = 12,
  parameter int          TESTNUM  = 50,
  parameter logic [31:0] SEED     = 32'h0000_0001,
  localparam int         CW       = $clog2(TESTNUM + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     mode,
  num_gen_if.master      nif,
  output logic [CW-1:0]  cnt,
  output logic           busy,
  output logic           done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [31:0]   SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [CW-1:0] LAST     = CW'(TESTNUM - 1);

  logic [1:0]          state;
  logic [31:0]         lfsr;
  logic [1:0]          mode_q;
  logic                xfer;
  logic [NUM_SIZE-1:0] shaped;

  assign xfer = (state == RUN) && nif.ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      lfsr   <= SEED_EFF;
      cnt    <= '0;
      mode_q <= 2'b00;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mode_q <= mode;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            cnt  <= cnt + CW'(1);
            lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
            if (cnt == LAST) begin
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Only bit 0 is shaped by the mode; alternate mode keys parity off the transfer count.
  always_comb begin
    shaped = lfsr[NUM_SIZE-1:0];
    case (mode_q)
      2'b01:   shaped[0] = 1'b0;
      2'b10:   shaped[0] = 1'b1;
      2'b11:   shaped[0] = cnt[0];
      default: ;
    endcase
  end

  assign nif.valid = (state == RUN);
  assign nif.num   = nif.valid ? shaped : '0;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_num_gen.sv
// Self-checking bench for num_gen: directed sequences plus randomized traffic against a behavioural model.
module tb_num_gen;
  localparam int NS = 12;
  localparam int TN = 50;

  logic       clk = 1'b0;
  logic       rst_n, start, ready;
  logic [1:0] mode;
  logic [5:0] cnt;
  logic       busy, done;
  logic       cnt2, busy2, done2;

  always #5 clk = ~clk;

  num_gen_if #(.NUM_SIZE(NS)) nif ();
  num_gen_if #(.NUM_SIZE(NS)) nif2 ();
  assign nif.ready  = ready;
  assign nif2.ready = ready;

  num_gen #(.NUM_SIZE(NS), .TESTNUM(TN), .SEED(32'h0000_0001)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .nif(nif), .cnt(cnt), .busy(busy), .done(done)
  );

  // Single-number run with a zero seed, which must behave as seed 1.
  num_gen #(.NUM_SIZE(NS), .TESTNUM(1), .SEED(32'h0000_0000)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .nif(nif2), .cnt(cnt2), .busy(busy2), .done(done2)
  );

  int n_vec  = 0;
  int n_fail = 0;
  int xfers  = 0;

  // Behavioural model: run flags, transfer count, latched mode and generator word.
  logic [31:0] m_lfsr;
  logic [1:0]  m_mode;
  int          m_cnt;
  bit          m_run, m_done;

  logic [11:0] tbl [4][4] = '{
    '{12'h001, 12'h003, 12'h006, 12'h00D},
    '{12'h000, 12'h002, 12'h006, 12'h00C},
    '{12'h001, 12'h003, 12'h007, 12'h00D},
    '{12'h000, 12'h003, 12'h006, 12'h00D}
  };

  function automatic logic [31:0] lstep(input logic [31:0] l);
    logic [31:0] fb;
    fb = 32'((l >> 31) ^ (l >> 21) ^ (l >> 1) ^ l) & 32'h1;
    return (l << 1) | fb;
  endfunction

  function automatic logic [31:0] form(input logic [31:0] l, input logic [1:0] md, input int c);
    logic [31:0] r;
    r = l % 32'h1000;
    case (md)
      2'd1:    r = r & ~32'h1;
      2'd2:    r = r | 32'h1;
      2'd3:    r = (r & ~32'h1) | 32'(c % 2);
      default: ;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: predict from the inputs applied before the edge, then compare all outputs after it.
  task automatic cyc();
    bit x;
    x = m_run && ready;
    if (nif.valid === 1'b1 && ready) xfers++;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_lfsr = 32'h1; m_cnt = 0; m_mode = 2'd0; m_run = 0; m_done = 0;
    end else if (m_run) begin
      if (x) begin
        m_lfsr = lstep(m_lfsr);
        m_cnt++;
        if (m_cnt == TN) begin
          m_run  = 0;
          m_done = 1;
        end
      end
    end else if (start) begin
      m_mode = mode; m_cnt = 0; m_run = 1; m_done = 0;
    end
    chk("valid", 32'(nif.valid), 32'(m_run));
    chk("busy",  32'(busy),      32'(m_run));
    chk("done",  32'(done),      32'(m_done));
    chk("cnt",   32'(cnt),       32'(m_cnt));
    chk("num",   32'(nif.num),   m_run ? form(m_lfsr, m_mode, m_cnt) : 32'h0);
  endtask

  initial begin
    logic [31:0] lsave;
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; ready = 1'b1;
    cyc();
    cyc();
    chk("rst_valid", 32'(nif.valid), 32'h0);
    chk("rst_num",   32'(nif.num),   32'h0);
    chk("rst_cnt",   32'(cnt),       32'h0);
    chk("rst_done",  32'(done),      32'h0);
    rst_n = 1'b1;
    cyc();

    // Each mode from a fresh reset; mode input flipped mid-run must not matter.
    for (int m = 0; m < 4; m++) begin
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      mode  = 2'(m);
      start = 1'b1;
      cyc();
      start = 1'b0;
      mode  = 2'(3 - m);
      if (m == 0) begin
        chk("d2_valid", 32'(nif2.valid), 32'h1);
        chk("d2_num",   32'(nif2.num),   32'h001);
      end
      for (int i = 0; i < 4; i++) begin
        chk("seq_num", 32'(nif.num), 32'(tbl[m][i]));
        chk("seq_cnt", 32'(cnt),     32'(i));
        cyc();
        if (m == 0 && i == 0) begin
          chk("d2_done",  32'(done2),      32'h1);
          chk("d2_valid_low", 32'(nif2.valid), 32'h0);
          chk("d2_cnt",   32'(cnt2),       32'h1);
        end
      end
    end

    // Backpressure: five stalled cycles, then a transfer with a stray start in RUN.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    mode  = 2'd0;
    ready = 1'b0;
    start = 1'b1;
    xfers = 0;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_num", 32'(nif.num), 32'h001);
      chk("bp_cnt", 32'(cnt),     32'h0);
      cyc();
    end
    ready = 1'b1;
    start = 1'b1;
    chk("bp_hold", 32'(nif.num), 32'h001);
    cyc();
    start = 1'b0;
    chk("bp_next",     32'(nif.num), 32'h003);
    chk("bp_next_cnt", 32'(cnt),     32'h1);

    // Finish the run under random ready/mode/start, bounded.
    for (int b = 0; b < 2000; b++) begin
      if (done) break;
      ready = ($urandom_range(0, 3) != 0);
      mode  = 2'($urandom);
      start = ($urandom_range(0, 7) == 0);
      cyc();
    end
    start = 1'b0;
    chk("full_done",  32'(done),      32'h1);
    chk("full_valid", 32'(nif.valid), 32'h0);
    chk("full_cnt",   32'(cnt),       32'd50);
    chk("full_xfers", 32'(xfers),     32'd50);

    // Restart from DONE continues the generator sequence.
    lsave = m_lfsr;
    ready = 1'b1;
    mode  = 2'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("re_valid", 32'(nif.valid), 32'h1);
    chk("re_cnt",   32'(cnt),       32'h0);
    chk("re_num",   32'(nif.num),   lsave % 32'h1000);

    // Reset mid-run after three transfers, with start asserted alongside reset.
    cyc();
    cyc();
    cyc();
    rst_n = 1'b0;
    start = 1'b1;
    cyc();
    chk("mr_valid", 32'(nif.valid), 32'h0);
    chk("mr_cnt",   32'(cnt),       32'h0);
    chk("mr_busy",  32'(busy),      32'h0);
    rst_n = 1'b1;
    cyc();
    start = 1'b0;
    chk("mr_replay", 32'(nif.num), 32'h001);

    // Long randomized soak with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      ready = ($urandom_range(0, 3) != 0);
      mode  = 2'($urandom);
      start = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      cyc();
    end
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
